demux1to2_16b_buf: RTL and testbench

//  Buffered 1-to-2 demultiplexer: steers a 16b input word stream onto output a or b by in_sel.

---
 rtl/demux_pkg.sv | 16 +
 rtl/fifo_sync_16b.sv | 52 +++++
 rtl/demux1to2_16b_buf.sv | 69 ++++++
 tb/tb_demux1to2_16b_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-2 word demultiplexer.
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/fifo_sync_16b.sv
// Single-clock FIFO with async active-low reset; head reads as zero while empty.
module fifo_sync_16b #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop request on an empty FIFO and a push into a full one are both no-ops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/demux1to2_16b_buf.sv
// Steers an input word stream into one of two output FIFOs; each output drains independently.
module demux1to2_16b_buf #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = demux_pkg::DEPTH
) (
  input  logic             clkpos,
  input  logic             rstn,
  input  logic             vdd,
  input  logic             vss,
  input  logic [WIDTH-1:0] in,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  input  logic             b_ready
);

  import demux_pkg::*;

  logic                  full_a, full_b;
  logic                  empty_a, empty_b;
  logic                  push_a, push_b;
  logic                  accept;
  logic [$clog2(DEPTH):0] count_a, count_b;
  sel_t                  sel;
  logic                  unused_ties;

  assign unused_ties = vdd ^ vss;
  assign sel         = sel_t'(in_sel);

  // Handshake: a word moves on a rising edge when valid and ready are both high.
  // in_ready looks only at the selected FIFO's registered fill, never at consumer readies.
  assign in_ready = rstn && !((sel == SEL_B) ? full_b : full_a);
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && (sel == SEL_A);
  assign push_b   = accept && (sel == SEL_B);

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;

  fifo_sync_16b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clkpos),
    .rst_n (rstn),
    .push  (push_a),
    .data  (in),
    .pop   (a_ready),
    .full  (full_a),
    .empty (empty_a),
    .head  (a),
    .count (count_a)
  );

  fifo_sync_16b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clkpos),
    .rst_n (rstn),
    .push  (push_b),
    .data  (in),
    .pop   (b_ready),
    .full  (full_b),
    .empty (empty_b),
    .head  (b),
    .count (count_b)
  );

endmodule

// File: tb/tb_demux1to2_16b_buf.sv
// Directed bench for the buffered 1-to-2 demultiplexer.
module tb_demux1to2_16b_buf;
  import demux_pkg::*;

  logic  clkpos;
  logic  rstn;
  logic  vdd;
  logic  vss;
  word_t in;
  logic  in_sel;
  logic  in_valid;
  logic  in_ready;
  word_t a;
  logic  a_valid;
  logic  a_ready;
  word_t b;
  logic  b_valid;
  logic  b_ready;

  int total_cnt;
  int pass_cnt;

  demux1to2_16b_buf dut (
    .clkpos   (clkpos),
    .rstn     (rstn),
    .vdd      (vdd),
    .vss      (vss),
    .in       (in),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b        (b),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  initial begin
    clkpos = 1'b0;
    forever #5 clkpos = ~clkpos;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clkpos);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input word_t d);
    in_valid = v;
    in_sel   = s;
    in       = d;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    vdd = 1'b1;
    vss = 1'b0;
    rstn = 1'b1;
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b0, 1'b0, 16'h0000);

    // 1 reset values, no clock edge yet
    #1 rstn = 1'b0;
    #1;
    check("rst_a", 32'(a), 32'h0);
    check("rst_b", 32'(b), 32'h0);
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_b_valid", 32'(b_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("rel_in_ready_sel0", 32'(in_ready), 32'h1);
    in_sel = 1'b1;
    #1;
    check("rel_in_ready_sel1", 32'(in_ready), 32'h1);

    // 2 single steer to a, then drain
    tick();
    drive(1'b1, 1'b0, 16'h1234);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    check("steer_a_valid", 32'(a_valid), 32'h1);
    check("steer_a", 32'(a), 32'h1234);
    check("steer_b_valid", 32'(b_valid), 32'h0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("drain_a_valid", 32'(a_valid), 32'h0);
    check("drain_a", 32'(a), 32'h0);

    // 3 backpressure on b does not block a
    drive(1'b1, 1'b1, 16'hAAAA);
    tick();
    drive(1'b1, 1'b1, 16'hBBBB);
    tick();
    drive(1'b0, 1'b1, 16'h0000);
    #1;
    check("bp_in_ready_sel1", 32'(in_ready), 32'h0);
    in_sel = 1'b0;
    #1;
    check("bp_in_ready_sel0", 32'(in_ready), 32'h1);
    check("bp_b_head", 32'(b), 32'hAAAA);
    drive(1'b1, 1'b0, 16'h5555);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    check("bp_a_head", 32'(a), 32'h5555);
    check("bp_b_still_valid", 32'(b_valid), 32'h1);
    b_ready = 1'b1;
    tick();
    check("bp_b_second", 32'(b), 32'hBBBB);
    tick();
    b_ready = 1'b0;
    check("bp_b_empty", 32'(b_valid), 32'h0);
    check("bp_b_zero", 32'(b), 32'h0);
    check("bp_a_kept", 32'(a), 32'h5555);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("bp_a_drained", 32'(a_valid), 32'h0);

    // 4 simultaneous push and pop, then full with pop
    drive(1'b1, 1'b0, 16'h0011);
    tick();
    check("sim_count_1", 32'(dut.u_fifo_a.count), 32'h1);
    drive(1'b1, 1'b0, 16'h0022);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("sim_a_head", 32'(a), 32'h0022);
    check("sim_count_same", 32'(dut.u_fifo_a.count), 32'h1);
    drive(1'b1, 1'b0, 16'h0033);
    tick();
    check("full_count", 32'(dut.u_fifo_a.count), 32'h2);
    drive(1'b1, 1'b0, 16'h0044);
    a_ready = 1'b1;
    #1;
    check("full_in_ready", 32'(in_ready), 32'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    check("full_pop_count", 32'(dut.u_fifo_a.count), 32'h1);
    check("full_pop_head", 32'(a), 32'h0033);
    tick();
    a_ready = 1'b0;
    check("full_no_leak", 32'(a_valid), 32'h0);

    // 5 asynchronous reset between edges
    drive(1'b1, 1'b0, 16'h0101);
    tick();
    drive(1'b1, 1'b0, 16'h0202);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    check("ar_count_2", 32'(dut.u_fifo_a.count), 32'h2);
    #2 rstn = 1'b0;
    #1;
    check("ar_a_valid", 32'(a_valid), 32'h0);
    check("ar_a", 32'(a), 32'h0);
    check("ar_in_ready", 32'(in_ready), 32'h0);
    #1 rstn = 1'b1;
    tick();
    check("ar_after_valid", 32'(a_valid), 32'h0);
    check("ar_after_a", 32'(a), 32'h0);
    check("ar_after_ready", 32'(in_ready), 32'h1);

    // 6 interleave with both consumers ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0001);
    tick();
    check("il_a1", 32'(a), 32'h0001);
    drive(1'b1, 1'b1, 16'h0002);
    tick();
    check("il_a_empty1", 32'(a_valid), 32'h0);
    check("il_b2", 32'(b), 32'h0002);
    drive(1'b1, 1'b0, 16'h0003);
    tick();
    check("il_a3", 32'(a), 32'h0003);
    check("il_b_empty1", 32'(b_valid), 32'h0);
    drive(1'b1, 1'b1, 16'h0004);
    tick();
    check("il_a_empty2", 32'(a_valid), 32'h0);
    check("il_b4", 32'(b), 32'h0004);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    check("il_b_empty2", 32'(b_valid), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
